// File: rtl/memstream_rd_ctrl_if.sv
// Memory read port plus AXI-Stream master bundle used by memstream_rd_ctrl.
interface memstream_rd_ctrl_if #(
  parameter int DWIDTH = 18,
  parameter int AWIDTH = 10
);
  logic              mem_en;
  logic              mem_enq;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_rdq;
  logic [DWIDTH-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;

  modport master (
    output mem_en, mem_enq, mem_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  mem_rdq, m_axis_tready
  );

  modport slave (
    input  mem_en, mem_enq, mem_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output mem_rdq, m_axis_tready
  );
endinterface

// File: rtl/memstream_rd_ctrl.sv
// Streams a 2-cycle-latency weight memory onto AXI-Stream with credit-based backpressure.
// aresetn asserts asynchronously; its release is expected to be synchronous to clk upstream.
module memstream_rd_ctrl #(
  parameter int DWIDTH = 18,
  parameter int AWIDTH = 10,
  parameter int DEPTH  = 2**AWIDTH,
  parameter int LOOP   = 1
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                start,
  input  logic                rewind,
  output logic                done,
  memstream_rd_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

  state_t                  state_q, state_d;
  logic [AWIDTH-1:0]       addr_q, addr_d;
  logic                    enq_q;
  logic [1:0]              tag_vld_q, tag_vld_d;
  logic [1:0]              tag_last_q, tag_last_d;
  logic [3:0][DWIDTH-1:0]  fifo_data_q, fifo_data_d;
  logic [3:0]              fifo_last_q, fifo_last_d;
  logic [1:0]              rd_ptr_q, rd_ptr_d;
  logic [1:0]              wr_ptr_q, wr_ptr_d;
  logic [2:0]              count_q, count_d;
  logic [2:0]              inflight;
  logic                    issue;
  logic                    push;
  logic                    pop;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    tag_vld_d   = tag_vld_q;
    tag_last_d  = tag_last_q;
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    done        = 1'b0;
    issue       = 1'b0;
    inflight    = {2'b00, tag_vld_q[0]} + {2'b00, tag_vld_q[1]};
    push        = tag_vld_q[1];
    pop         = (count_q != 3'd0) && bus.m_axis_tready;

    if (rewind) begin
      state_d    = STREAM;
      addr_d     = '0;
      tag_vld_d  = 2'b00;
      tag_last_d = 2'b00;
      rd_ptr_d   = 2'd0;
      wr_ptr_d   = 2'd0;
      count_d    = 3'd0;
    end else begin
      // Credits cover FIFO slots plus reads still inside the memory pipeline.
      issue      = (state_q == STREAM) && ((count_q + inflight) < 3'd4);
      tag_vld_d  = {tag_vld_q[0], issue};
      tag_last_d = {tag_last_q[0], issue && (addr_q == LAST_ADDR)};
      if (push) begin
        fifo_data_d[wr_ptr_q] = bus.mem_rdq;
        fifo_last_d[wr_ptr_q] = tag_last_q[1];
        wr_ptr_d              = wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 2'd1;
      end
      count_d = count_q + {2'b00, push} - {2'b00, pop};
      if (issue) begin
        addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (start || (LOOP != 0)) begin
            state_d = STREAM;
            addr_d  = '0;
          end
        end
        STREAM: begin
          if (issue && (addr_q == LAST_ADDR) && (LOOP == 0)) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if ((count_q == 3'd0) && (inflight == 3'd0)) begin
            state_d = IDLE;
            done    = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      enq_q       <= 1'b0;
      tag_vld_q   <= 2'b00;
      tag_last_q  <= 2'b00;
      fifo_data_q <= '0;
      fifo_last_q <= 4'b0000;
      rd_ptr_q    <= 2'd0;
      wr_ptr_q    <= 2'd0;
      count_q     <= 3'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      enq_q       <= 1'b1;
      tag_vld_q   <= tag_vld_d;
      tag_last_q  <= tag_last_d;
      fifo_data_q <= fifo_data_d;
      fifo_last_q <= fifo_last_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

  assign bus.mem_en        = issue;
  assign bus.mem_enq       = enq_q;
  assign bus.mem_addr      = addr_q;
  assign bus.m_axis_tvalid = (count_q != 3'd0);
  assign bus.m_axis_tdata  = fifo_data_q[rd_ptr_q];
  assign bus.m_axis_tlast  = (count_q != 3'd0) && fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_memstream_rd_ctrl.sv
// Three controllers (DEPTH 8 looping, DEPTH 5 single pass, DEPTH 1 looping) on a shared clock/reset,
// each backed by a 2-cycle memory holding mem[i]=i and checked against a word-sequence model.
module tb_memstream_rd_ctrl;
  localparam int DW = 18;
  localparam int AW = 10;

  logic                  clk;
  logic                  aresetn;
  logic [2:0]            start;
  logic [2:0]            rewind;
  logic [2:0]            tready;
  logic [2:0]            done;
  logic [2:0]            tvalid;
  logic [2:0]            tlast;
  logic [2:0]            mem_en;
  logic [2:0]            mem_enq;
  logic [2:0][DW-1:0]    tdata;
  logic [2:0][AW-1:0]    mem_addr;

  int compared;
  int mismatched;

  int          exp_idx     [3];
  int          exp_addr    [3];
  int          outstanding [3];
  int          issued      [3];
  int          acc_cnt     [3];
  int          done_cnt    [3];
  bit          idle        [3];
  bit          prev_stall  [3];
  bit          last_acc    [3];
  bit          want_first  [3];
  logic [DW-1:0] held_data [3];
  logic        held_last   [3];
  logic [DW-1:0] first_word[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D = (g == 0) ? 8 : ((g == 1) ? 5 : 1);
    localparam int L = (g == 1) ? 0 : 1;
    logic [DW-1:0] dreg;

    memstream_rd_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    memstream_rd_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(D), .LOOP(L)) dut (
      .clk     (clk),
      .aresetn (aresetn),
      .start   (start[g]),
      .rewind  (rewind[g]),
      .done    (done[g]),
      .bus     (bus)
    );

    assign bus.m_axis_tready = tready[g];
    assign tvalid[g]   = bus.m_axis_tvalid;
    assign tlast[g]    = bus.m_axis_tlast;
    assign tdata[g]    = bus.m_axis_tdata;
    assign mem_en[g]   = bus.mem_en;
    assign mem_enq[g]  = bus.mem_enq;
    assign mem_addr[g] = bus.mem_addr;

    always @(posedge clk) begin
      if (bus.mem_en)  dreg <= DW'(bus.mem_addr);
      if (bus.mem_enq) bus.mem_rdq <= dreg;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] rdy, input logic [2:0] st, input logic [2:0] rw);
    @(posedge clk);
    #1;
    tready = rdy;
    start  = st;
    rewind = rw;
  endtask

  // Model: each sample describes what the next rising edge will do; words must leave in address order.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      int d;
      bit lp;
      bit xfer;
      d  = (g == 0) ? 8 : ((g == 1) ? 5 : 1);
      lp = (g != 1);
      if (!aresetn) begin
        exp_idx[g] = 0; exp_addr[g] = 0; outstanding[g] = 0; issued[g] = 0;
        idle[g] = 1'b1; prev_stall[g] = 1'b0; last_acc[g] = 1'b0; want_first[g] = 1'b0;
      end else begin
        checkOutput($sformatf("u%0d_done", g), 32'(done[g]), 32'(last_acc[g]));
        if (done[g]) done_cnt[g]++;
        if (last_acc[g]) idle[g] = 1'b1;
        if (prev_stall[g]) begin
          checkOutput($sformatf("u%0d_hold_valid", g), 32'(tvalid[g]), 32'd1);
          checkOutput($sformatf("u%0d_hold_data", g), 32'(tdata[g]), 32'(held_data[g]));
          checkOutput($sformatf("u%0d_hold_last", g), 32'(tlast[g]), 32'(held_last[g]));
        end
        if (mem_en[g]) begin
          checkOutput($sformatf("u%0d_addr", g), 32'(mem_addr[g]), 32'(exp_addr[g]));
          checkOutput($sformatf("u%0d_credit", g), 32'(outstanding[g] < 4), 32'd1);
          if (!lp) checkOutput($sformatf("u%0d_pass_issue", g), 32'(!idle[g] && issued[g] < d), 32'd1);
          outstanding[g]++;
          issued[g]++;
          exp_addr[g] = (exp_addr[g] + 1) % d;
        end
        xfer = tvalid[g] && tready[g];
        last_acc[g] = 1'b0;
        if (xfer) begin
          checkOutput($sformatf("u%0d_data", g), 32'(tdata[g]), 32'(exp_idx[g]));
          checkOutput($sformatf("u%0d_last", g), 32'(tlast[g]), 32'(exp_idx[g] == d - 1));
          if (want_first[g]) begin
            first_word[g] = tdata[g];
            want_first[g] = 1'b0;
          end
          last_acc[g] = !lp && (exp_idx[g] == d - 1);
          exp_idx[g] = (exp_idx[g] + 1) % d;
          outstanding[g]--;
          acc_cnt[g]++;
        end
        if (rewind[g]) begin
          checkOutput($sformatf("u%0d_rewind_noissue", g), 32'(mem_en[g]), 32'd0);
          exp_idx[g] = 0; exp_addr[g] = 0; outstanding[g] = 0; issued[g] = 0;
          idle[g] = 1'b0; prev_stall[g] = 1'b0; last_acc[g] = 1'b0; want_first[g] = 1'b1;
        end else begin
          prev_stall[g] = tvalid[g] && !tready[g];
          held_data[g]  = tdata[g];
          held_last[g]  = tlast[g];
          if (start[g] && idle[g] && !lp) begin
            idle[g]   = 1'b0;
            issued[g] = 0;
          end
        end
      end
    end
  end

  initial begin
    int target;
    int cyc;
    int a0;
    compared = 0;
    mismatched = 0;
    for (int g = 0; g < 3; g++) begin
      acc_cnt[g] = 0;
      done_cnt[g] = 0;
    end
    aresetn = 1'b0;
    start   = 3'b000;
    rewind  = 3'b000;
    tready  = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      checkOutput($sformatf("rst_u%0d_tvalid", g), 32'(tvalid[g]), 32'd0);
      checkOutput($sformatf("rst_u%0d_tlast", g), 32'(tlast[g]), 32'd0);
      checkOutput($sformatf("rst_u%0d_tdata", g), 32'(tdata[g]), 32'd0);
      checkOutput($sformatf("rst_u%0d_mem_en", g), 32'(mem_en[g]), 32'd0);
      checkOutput($sformatf("rst_u%0d_mem_enq", g), 32'(mem_enq[g]), 32'd0);
      checkOutput($sformatf("rst_u%0d_mem_addr", g), 32'(mem_addr[g]), 32'd0);
      checkOutput($sformatf("rst_u%0d_done", g), 32'(done[g]), 32'd0);
    end

    // Looping stream at full rate: first word three edges after the release edge.
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    tready  = 3'b111;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("t1_first_valid_k%0d", k), 32'(tvalid[0]), 32'(k == 3));
    end
    checkOutput("t1_first_data", 32'(tdata[0]), 32'd0);
    checkOutput("t1_enq_high", 32'(mem_enq[0]), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("t1_valid", 32'(tvalid[0]), 32'd1);
      checkOutput("t1_data", 32'(tdata[0]), 32'(k % 8));
      checkOutput("t1_last", 32'(tlast[0]), 32'((k % 8) == 7));
    end

    target = acc_cnt[0] + 1000;
    cyc = 0;
    while (acc_cnt[0] < target && cyc < 6000) begin
      applyStimulus({1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1))}, 3'b000, 3'b000);
      cyc++;
    end
    checkOutput("t2_words_streamed", 32'(acc_cnt[0] >= target), 32'd1);

    repeat (20) applyStimulus(3'b110, 3'b000, 3'b000);
    @(negedge clk);
    #1;
    checkOutput("t3_valid_held", 32'(tvalid[0]), 32'd1);
    checkOutput("t3_mem_en_low", 32'(mem_en[0]), 32'd0);
    checkOutput("t3_buffered", 32'(outstanding[0]), 32'd4);
    a0 = acc_cnt[0];
    for (int k = 0; k < 12; k++) begin
      applyStimulus(3'b111, 3'b000, 3'b000);
      @(negedge clk);
      checkOutput("t3_gapless", 32'(tvalid[0]), 32'd1);
    end
    #1;
    checkOutput("t3_resume_count", 32'(acc_cnt[0] - a0), 32'd12);

    // Single pass; the second start lands while streaming and must be ignored.
    a0 = acc_cnt[1];
    applyStimulus(3'b111, 3'b010, 3'b000);
    applyStimulus(3'b111, 3'b000, 3'b000);
    applyStimulus(3'b111, 3'b010, 3'b000);
    repeat (20) applyStimulus(3'b111, 3'b000, 3'b000);
    @(negedge clk);
    #1;
    checkOutput("t4_words", 32'(acc_cnt[1] - a0), 32'd5);
    checkOutput("t4_done_pulses", 32'(done_cnt[1]), 32'd1);
    checkOutput("t4_mem_en_idle", 32'(mem_en[1]), 32'd0);
    checkOutput("t4_tvalid_idle", 32'(tvalid[1]), 32'd0);

    repeat (4) applyStimulus(3'b111, 3'b000, 3'b000);
    applyStimulus(3'b110, 3'b000, 3'b000);
    applyStimulus(3'b110, 3'b000, 3'b000);
    applyStimulus(3'b110, 3'b000, 3'b001);
    applyStimulus(3'b110, 3'b000, 3'b000);
    @(negedge clk);
    checkOutput("t5_flushed_valid", 32'(tvalid[0]), 32'd0);
    cyc = 0;
    applyStimulus(3'b111, 3'b000, 3'b000);
    while (want_first[0] && cyc < 20) begin
      applyStimulus(3'b111, 3'b000, 3'b000);
      cyc++;
    end
    checkOutput("t5_word_seen", 32'(want_first[0]), 32'd0);
    checkOutput("t5_first_word", 32'(first_word[0]), 32'd0);

    repeat (6) applyStimulus(3'b111, 3'b000, 3'b000);
    @(posedge clk);
    #2;
    aresetn = 1'b0;
    #1;
    checkOutput("t6_tvalid_drop", 32'(tvalid[0]), 32'd0);
    checkOutput("t6_mem_en_drop", 32'(mem_en[0]), 32'd0);
    checkOutput("t6_addr_clear", 32'(mem_addr[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("t6_restart_valid_k%0d", k), 32'(tvalid[0]), 32'(k == 3));
    end
    checkOutput("t6_restart_data", 32'(tdata[0]), 32'd0);
    repeat (20) applyStimulus(3'b111, 3'b000, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
